// File: rtl/data_mem_slave.sv
// rtl/data_mem_slave.sv - word-organised data memory slave with one outstanding request and fixed response latency
// Optional misaligned-access check enabled by defining DATA_MEM_SLAVE_MISALIGN_CHK_EN.
module data_mem_slave #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [2:0]  cap_func3;
    logic [3:0]  cap_wmask;
    logic [31:0] cap_wdata;
    logic [31:0] mem [DEPTH];

    logic        handshake, enter_resp, commit, misal;
    logic        act_we;
    logic [31:0] act_addr, act_wdata;
    logic [2:0]  act_func3;
    logic [3:0]  act_wmask;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0] word, shifted, load_val, wdata_sh;
    logic [3:0]  wmask_sh;
    logic        unused_ok;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign handshake  = req_valid && req_ready;

    // With LATENCY = 1 the commit edge is the handshake edge, so use the live request there.
    assign act_we    = (state == S_IDLE) ? req_we    : cap_we;
    assign act_addr  = (state == S_IDLE) ? req_addr  : cap_addr;
    assign act_func3 = (state == S_IDLE) ? req_func3 : cap_func3;
    assign act_wmask = (state == S_IDLE) ? req_wmask : cap_wmask;
    assign act_wdata = (state == S_IDLE) ? req_wdata : cap_wdata;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 3'd0) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);

    assign idx      = act_addr[DEPTH_LOG2+1:2];
    assign word     = mem[idx];
    assign shifted  = word >> {act_addr[1:0], 3'b000};
    assign wdata_sh = act_wdata << {act_addr[1:0], 3'b000};
    assign wmask_sh = act_wmask << act_addr[1:0];

`ifdef DATA_MEM_SLAVE_MISALIGN_CHK_EN
    assign misal = (((act_func3 == 3'b001) || (act_func3 == 3'b101)) && act_addr[0]) ||
                   ((act_func3 == 3'b010) && (act_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        load_val = shifted;
        case (act_func3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'b0, shifted[7:0]};
            3'b101:  load_val = {16'b0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign commit    = enter_resp && !rst && act_we && !misal;
    assign unused_ok = ^{act_addr[31:DEPTH_LOG2+2]};

    // No reset on the array: contents survive rst.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_sh[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_func3 <= req_func3;
                cap_wmask <= req_wmask;
                cap_wdata <= req_wdata;
                cnt       <= CNT_INIT;
            end else if ((state == S_WAIT) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (enter_resp) begin
                resp_rdata <= (act_we || misal) ? 32'd0 : load_val;
                resp_err   <= misal;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_slave.sv
// tb/tb_data_mem_slave.sv - directed self-checking bench for data_mem_slave
module tb_data_mem_slave;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_func3 = 3'd0;
    logic [3:0]  req_wmask = 4'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;

    data_mem_slave #(.DEPTH_LOG2(12), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_func3  (req_func3),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [3:0] mask, input logic [31:0] wd, input int hold,
                          output logic [31:0] rdata, output logic err);
        int n;
        logic [31:0] first;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_func3 = f3;
        req_wmask = mask; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b1; req_addr = 32'hFFFF_FFFC;
        req_wmask = 4'hF; req_wdata = 32'h0BAD_0BAD;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        rdata = resp_rdata;
        err   = resp_err;
        first = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, first);
        end
        resp_ready = 1'b1;
        check("exit_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("back_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);

        access(1'b1, 32'h100, 3'b010, 4'hF, 32'hDEAD_BEEF, 0, rd, er);
        check("sw_rdata_zero", rd, 32'd0);
        check("sw_err", 32'(er), 32'd0);
        access(1'b0, 32'h100, 3'b010, 4'h0, 32'd0, 0, rd, er);
        check("lw_100", rd, 32'hDEAD_BEEF);

        access(1'b0, 32'h103, 3'b000, 4'h0, 32'd0, 0, rd, er);
        check("lb_103", rd, 32'hFFFF_FFDE);
        access(1'b0, 32'h103, 3'b100, 4'h0, 32'd0, 0, rd, er);
        check("lbu_103", rd, 32'h0000_00DE);
        access(1'b0, 32'h102, 3'b001, 4'h0, 32'd0, 0, rd, er);
        check("lh_102", rd, 32'hFFFF_DEAD);
        access(1'b0, 32'h100, 3'b101, 4'h0, 32'd0, 0, rd, er);
        check("lhu_100", rd, 32'h0000_BEEF);

        access(1'b1, 32'h101, 3'b000, 4'h1, 32'h0000_0055, 0, rd, er);
        access(1'b0, 32'h100, 3'b010, 4'h0, 32'd0, 5, rd, er);
        check("lw_after_sb", rd, 32'hDEAD_55EF);

        access(1'b1, 32'h4104, 3'b010, 4'hF, 32'hA5A5_5A5A, 0, rd, er);
        access(1'b0, 32'hFFFF_0104, 3'b010, 4'h0, 32'd0, 0, rd, er);
        check("wrap_lw", rd, 32'hA5A5_5A5A);

        access(1'b1, 32'h200, 3'b010, 4'hF, 32'hCAFE_F00D, 0, rd, er);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_func3 = 3'b010;
        req_wmask = 4'hF; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_wait_valid", 32'(resp_valid), 32'd0);
            check("rst_wait_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
        end
        access(1'b0, 32'h200, 3'b010, 4'h0, 32'd0, 0, rd, er);
        check("lw_200_prior", rd, 32'hCAFE_F00D);

        access(1'b1, 32'h102, 3'b010, 4'hF, 32'h1122_3344, 0, rd, er);
`ifdef DATA_MEM_SLAVE_MISALIGN_CHK_EN
        check("mis_sw_err", 32'(er), 32'd1);
        access(1'b0, 32'h100, 3'b010, 4'h0, 32'd0, 0, rd, er);
        check("mis_mem_same", rd, 32'hDEAD_55EF);
        access(1'b0, 32'h102, 3'b010, 4'h0, 32'd0, 0, rd, er);
        check("mis_lw_err", 32'(er), 32'd1);
        check("mis_lw_rdata", rd, 32'd0);
`else
        check("mis_sw_err", 32'(er), 32'd0);
        access(1'b0, 32'h100, 3'b010, 4'h0, 32'd0, 0, rd, er);
        check("mis_trunc_store", rd, 32'h3344_55EF);
        access(1'b0, 32'h102, 3'b010, 4'h0, 32'd0, 0, rd, er);
        check("mis_lw_err", 32'(er), 32'd0);
        check("mis_lw_rdata", rd, 32'h0000_3344);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_slave.md
DATA_MEM_SLAVE -- requirements
Module: data_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, legal 1..7, meaning the number of cycles from request handshake to first resp_valid.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  slave can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_func3  input  3  RV32 load/store width code.
REQ-010 SHALL have port req_wmask  input  4  byte enables, unshifted (bit0 = lowest byte of req_wdata).
REQ-011 SHALL have port req_wdata  input  32  store data, unshifted, low-aligned.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  requester accepts response.
REQ-014 SHALL have port resp_rdata  output  32  load result, extended.
REQ-015 SHALL have port resp_err  output  1  misaligned-access error flag.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-017 SHALL capture req_we, req_addr, req_func3, req_wmask and req_wdata on the edge where req_valid && req_ready (cycle T); inputs are ignored at all other times.
REQ-018 SHALL assert resp_valid first in cycle T+LATENCY: LATENCY = 1 goes IDLE -> RESP directly; otherwise a down-counter loaded with LATENCY-2 holds WAIT until it reaches 0.
REQ-019 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1, then return to IDLE on that edge; there is no back-to-back acceptance in the RESP-exit cycle.
REQ-020 SHALL index the memory with captured addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
REQ-021 SHALL commit a store exactly once, on the edge entering RESP: data shifted left by 8*addr[1:0], mask shifted left by addr[1:0], lanes beyond byte 3 dropped.
REQ-022 SHALL form the load result by shifting the word right by 8*addr[1:0], then: 000 sign-extend byte; 001 sign-extend half; 010 full word; 100 zero-extend byte; 101 zero-extend half; other codes full shifted word.
REQ-023 SHALL read memory in the same edge as the store would commit, and SHALL drive resp_rdata = 0 for stores.
REQ-024 SHALL reflect a store in any later load; there is no read-during-write hazard because only one access is outstanding.

Reset
REQ-025 SHALL on rst = 1 go to IDLE, clear the counter, and drive resp_valid = 0, resp_rdata = 0 and resp_err = 0; req_ready = 1 in the cycle after reset.
REQ-026 SHALL discard a store captured but not yet committed when rst asserts in WAIT; rst asserted in RESP drops the response.
REQ-027 SHALL leave memory contents unaffected by reset.

Configuration
REQ-028 SHALL, with DATA_MEM_SLAVE_MISALIGN_CHK_EN defined, flag half accesses with addr[0] = 1 and word accesses with addr[1:0] != 0: resp_err = 1, no store commit, resp_rdata = 0, same latency.
REQ-029 SHALL, without DATA_MEM_SLAVE_MISALIGN_CHK_EN, tie resp_err to 0 and perform misaligned accesses per REQ-021/REQ-022 with lane truncation.

Verification
REQ-030 SHALL cover: LATENCY = 2, store word 0xDEADBEEF at 0x100, mask 0xF, then lw at 0x100 -> resp_valid at T+2 of each access, rdata 0xDEADBEEF.
REQ-031 SHALL cover: after REQ-030, lb at 0x103 -> 0xFFFFFFDE; lbu at 0x103 -> 0x000000DE; lh at 0x102 -> 0xFFFFDEAD; lhu at 0x100 -> 0x0000BEEF.
REQ-032 SHALL cover: sb 0x55 at 0x101, mask 0x1, then lw at 0x100 -> 0xDEAD55EF.
REQ-033 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and rdata stable, req_ready = 0 throughout, IDLE one edge after resp_ready = 1.
REQ-034 SHALL cover: rst pulsed in WAIT of a store of 0x12345678 to 0x200 -> no resp_valid; a following lw at 0x200 returns the prior contents.
REQ-035 SHALL cover: with DATA_MEM_SLAVE_MISALIGN_CHK_EN defined, sw at 0x102 -> resp_err = 1 and memory unchanged; without it, resp_err = 0.
